// File: rtl/l2_banked_mem_pm_if.sv
// Bus between the SoC interconnect and the banked L2: req/gnt handshake,
// write data path and the one-cycle-latency read return.
interface l2_banked_mem_pm_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 8
);
  localparam int NB = $clog2(NUM_BANKS);

  logic                        REQ;
  logic                        GNT;
  logic                        WEN;
  logic [DATA_WIDTH/8-1:0]     BEN;
  logic [BANK_ADDR_WIDTH+NB-1:0] A;
  logic [DATA_WIDTH-1:0]       D;
  logic [DATA_WIDTH-1:0]       Q;
  logic                        RVALID;

  modport master (output REQ, WEN, BEN, A, D, input GNT, Q, RVALID);
  modport slave  (input REQ, WEN, BEN, A, D, output GNT, Q, RVALID);
endinterface

// File: rtl/l2_banked_mem_pm.sv
// Banked L2 memory model with per-bank power management (idle timeout,
// forced sleep with retention, wake latency). Accesses to a bank that is
// not awake are stalled by withholding GNT.

// Latch-based clock gate: enable sampled while the clock is low.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic en_q;

  // Transparent while clk_i is low so the enable cannot glitch clk_o.
  always_latch
    if (!clk_i) en_q = en_i | test_en_i;

  assign clk_o = clk_i & en_q;
endmodule

// One bank: storage, read register and the AWAKE/SLEEP/WAKING FSM.
module l2_bank #(
  parameter int DW   = 32,
  parameter int AW   = 12,
  parameter int IDLE = 16,
  parameter int WAKE = 4
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic            req,
  input  logic            gnt,
  input  logic            wen,
  input  logic [DW/8-1:0] ben,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   d,
  input  logic            sleep_req,
  output logic            awake,
  output logic [DW-1:0]   rdata
);
  localparam int BW = DW / 8;
  localparam int IW = (IDLE > 0) ? $clog2(IDLE + 1) : 1;
  localparam int WW = $clog2(WAKE + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE);
  localparam logic [WW-1:0] WAKE_LD  = WW'(WAKE);

  typedef enum logic [1:0] {ST_AWAKE, ST_SLEEP, ST_WAKING} state_t;

  state_t          state;
  logic [IW-1:0]   idle_cnt;
  logic [WW-1:0]   wake_cnt;
  logic [DW-1:0]   mem [0:(2**AW)-1];

  // Power FSM; a request in the timeout/sleep_req cycle keeps the bank awake.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state    <= ST_AWAKE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ST_AWAKE: begin
          if (gnt)                    idle_cnt <= '0;
          else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
          if (!req && (sleep_req || (IDLE != 0 && idle_cnt == IDLE_MAX)))
            state <= ST_SLEEP;
        end
        ST_SLEEP: begin
          if (req) begin
            state    <= ST_WAKING;
            wake_cnt <= WAKE_LD;
          end
        end
        ST_WAKING: begin
          wake_cnt <= wake_cnt - 1'b1;
          if (wake_cnt == WW'(1)) begin
            state    <= ST_AWAKE;
            idle_cnt <= '0;
          end
        end
        default: state <= ST_AWAKE;
      endcase
    end
  end

  assign awake = (state == ST_AWAKE);

  // Byte-masked write; storage is never reset so contents survive RSTN.
  always_ff @(posedge gclk) begin
    if (gnt && !wen)
      for (int k = 0; k < BW; k++)
        if (!ben[k]) mem[addr][8*k +: 8] <= d[8*k +: 8];
  end

  // Read register holds the last read word until the next granted read.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)         rdata <= '0;
    else if (gnt && wen) rdata <= mem[addr];
  end
endmodule

// Top: bank decode, grant, read-return mux and clock gate.
module l2_banked_mem_pm #(
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 8,
  parameter int IDLE_CYCLES     = 16,
  parameter int WAKE_CYCLES     = 4
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 scan_en_in,
  l2_banked_mem_pm_if.slave    bus,
  input  logic [NUM_BANKS-1:0] SLEEP_REQ,
  output logic [NUM_BANKS-1:0] BANK_AWAKE
);
  localparam int NB = $clog2(NUM_BANKS);
  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = BANK_ADDR_WIDTH;

  typedef struct packed {
    logic                  wen;
    logic [BW-1:0]         ben;
    logic [NB-1:0]         bank;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] d;
  } req_t;

  logic                                  gclk;
  req_t                                  rq;
  logic [NUM_BANKS-1:0]                  req_hit;
  logic [NUM_BANKS-1:0]                  gnt_hit;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  rdata;
  logic [NB-1:0]                         sel;
  logic                                  rvalid;
  logic                                  gnt;

  pulp_clock_gating u_cg (
    .clk_i     (CLK),
    .en_i      (~scan_en_in),
    .test_en_i (1'b0),
    .clk_o     (gclk)
  );

  assign rq = {bus.WEN, bus.BEN, bus.A, bus.D};

  // One-hot request decode; grant only to an awake bank outside scan.
  always_comb begin
    req_hit          = '0;
    req_hit[rq.bank] = bus.REQ;
    gnt_hit          = req_hit & BANK_AWAKE & {NUM_BANKS{~scan_en_in}};
  end

  assign gnt = |gnt_hit;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    l2_bank #(
      .DW   (DATA_WIDTH),
      .AW   (AW),
      .IDLE (IDLE_CYCLES),
      .WAKE (WAKE_CYCLES)
    ) u_bank (
      .gclk      (gclk),
      .grst_n    (RSTN),
      .req       (req_hit[i]),
      .gnt       (gnt_hit[i]),
      .wen       (rq.wen),
      .ben       (rq.ben),
      .addr      (rq.addr),
      .d         (rq.d),
      .sleep_req (SLEEP_REQ[i]),
      .awake     (BANK_AWAKE[i]),
      .rdata     (rdata[i])
    );
  end

  // Read-return select and valid; sel only moves on a granted read so Q holds.
  always_ff @(posedge gclk or negedge RSTN) begin
    if (!RSTN) begin
      rvalid <= 1'b0;
      sel    <= '0;
    end else begin
      rvalid <= gnt & rq.wen;
      if (gnt && rq.wen) sel <= rq.bank;
    end
  end

  assign bus.GNT    = gnt;
  assign bus.RVALID = rvalid;
  assign bus.Q      = rdata[sel];
endmodule

// File: tb/tb_l2_banked_mem_pm.sv
// Directed bench for l2_banked_mem_pm with hand-computed expectations.
module tb_l2_banked_mem_pm;
  logic       CLK;
  logic       RSTN;
  logic       scan_en_in;
  logic [7:0] SLEEP_REQ;
  logic [7:0] BANK_AWAKE;
  int vectors;
  int miscompares;

  l2_banked_mem_pm_if #(.DATA_WIDTH(32), .BANK_ADDR_WIDTH(12), .NUM_BANKS(8)) bus ();

  l2_banked_mem_pm dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .scan_en_in (scan_en_in),
    .bus        (bus),
    .SLEEP_REQ  (SLEEP_REQ),
    .BANK_AWAKE (BANK_AWAKE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic acc(input logic w, input logic [3:0] ben, input logic [14:0] a,
                     input logic [31:0] d);
    bus.REQ = 1'b1;
    bus.WEN = w;
    bus.BEN = ben;
    bus.A   = a;
    bus.D   = d;
  endtask

  task automatic idle_bus();
    bus.REQ = 1'b0;
    bus.WEN = 1'b1;
    bus.BEN = 4'hF;
    bus.A   = '0;
    bus.D   = '0;
  endtask

  // Reset pulse released at a negedge: the current cycle is cycle 0.
  task automatic do_reset();
    RSTN = 1'b0;
    idle_bus();
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    scan_en_in  = 1'b0;
    SLEEP_REQ   = '0;
    idle_bus();
    @(negedge CLK);
    do_reset();

    // Reset state
    chk("rst_q", bus.Q, 32'h0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_awake", BANK_AWAKE, 8'hFF);

    // Write then read back, 1-cycle latency
    acc(1'b0, 4'h0, 15'h0005, 32'hDEADBEEF); #1;
    chk("wr0_gnt", bus.GNT, 1'b1);
    tick();
    acc(1'b1, 4'h0, 15'h0005, 32'h0); #1;
    chk("rd0_gnt", bus.GNT, 1'b1);
    chk("rd0_rvalid_after_wr", bus.RVALID, 1'b0);
    tick();
    idle_bus();
    chk("rd0_rvalid", bus.RVALID, 1'b1);
    chk("rd0_q", bus.Q, 32'hDEADBEEF);

    // Byte enables
    acc(1'b0, 4'h0, 15'h1010, 32'h11223344);
    tick();
    acc(1'b0, 4'b1010, 15'h1010, 32'hAABBCCDD);
    tick();
    acc(1'b1, 4'hF, 15'h1010, 32'h0);
    tick();
    acc(1'b0, 4'h0, 15'h3003, 32'hC0FFEE03);
    chk("ben_q", bus.Q, 32'h11BB33DD);
    chk("ben_rvalid", bus.RVALID, 1'b1);
    tick();
    idle_bus();
    chk("wr_rvalid_low", bus.RVALID, 1'b0);
    chk("q_hold_after_wr", bus.Q, 32'h11BB33DD);

    // Idle timeout from reset, then wake bank 3
    do_reset();
    repeat (16) tick();
    chk("idle_c16_awake", BANK_AWAKE, 8'hFF);
    tick();
    chk("idle_c17_asleep", BANK_AWAKE, 8'h00);
    repeat (13) tick();
    acc(1'b1, 4'hF, 15'h3003, 32'h0); #1;
    chk("wake_c30_gnt", bus.GNT, 1'b0);
    repeat (4) tick();
    chk("wake_c34_gnt", bus.GNT, 1'b0);
    chk("wake_c34_awake", BANK_AWAKE, 8'h00);
    tick();
    chk("wake_c35_gnt", bus.GNT, 1'b1);
    chk("wake_c35_awake", BANK_AWAKE, 8'h08);
    tick();
    idle_bus();
    chk("wake_c36_rvalid", bus.RVALID, 1'b1);
    chk("wake_c36_q", bus.Q, 32'hC0FFEE03);

    // Forced sleep, and sleep_req colliding with a request
    do_reset();
    SLEEP_REQ = 8'h04;
    tick();
    chk("fsleep_b2", BANK_AWAKE, 8'hFB);
    SLEEP_REQ = 8'h24;
    acc(1'b0, 4'h0, 15'h5000, 32'h00000055); #1;
    chk("fsleep_b5_gnt", bus.GNT, 1'b1);
    tick();
    chk("fsleep_b5_awake", BANK_AWAKE, 8'hFB);
    SLEEP_REQ = 8'h00;
    acc(1'b1, 4'hF, 15'h5000, 32'h0); #1;
    chk("b5_rd_gnt", bus.GNT, 1'b1);
    tick();
    chk("b5_rd_q", bus.Q, 32'h00000055);

    // Bank mux and hold
    acc(1'b0, 4'h0, 15'h0000, 32'h000000A0);
    tick();
    acc(1'b0, 4'h0, 15'h7000, 32'h000000A7);
    tick();
    acc(1'b1, 4'hF, 15'h0000, 32'h0);
    tick();
    acc(1'b1, 4'hF, 15'h7000, 32'h0);
    chk("mux_b0_q", bus.Q, 32'h000000A0);
    tick();
    idle_bus();
    chk("mux_b7_q", bus.Q, 32'h000000A7);
    chk("mux_b7_rvalid", bus.RVALID, 1'b1);
    tick();
    chk("hold_q", bus.Q, 32'h000000A7);
    chk("hold_rvalid", bus.RVALID, 1'b0);

    // Reset while bank 2 is waking with counter at 2
    acc(1'b1, 4'hF, 15'h2000, 32'h0); #1;
    chk("b2_sleep_gnt", bus.GNT, 1'b0);
    repeat (3) tick();
    chk("b2_waking", BANK_AWAKE, 8'hFB);
    RSTN = 1'b0;
    idle_bus();
    #1;
    chk("midwake_rst_awake", BANK_AWAKE, 8'hFF);
    chk("midwake_rst_q", bus.Q, 32'h0);
    chk("midwake_rst_rvalid", bus.RVALID, 1'b0);
    tick();
    RSTN = 1'b1;
    acc(1'b1, 4'hF, 15'h1010, 32'h0); #1;
    chk("post_rst_gnt", bus.GNT, 1'b1);
    tick();
    acc(1'b1, 4'hF, 15'h0005, 32'h0);
    chk("post_rst_b1_q", bus.Q, 32'h11BB33DD);
    tick();
    idle_bus();
    chk("post_rst_b0_q", bus.Q, 32'hDEADBEEF);

    // Scan freezes the block: no grant, no write
    scan_en_in = 1'b1;
    acc(1'b0, 4'h0, 15'h0005, 32'h12345678); #1;
    chk("scan_gnt", bus.GNT, 1'b0);
    tick();
    tick();
    scan_en_in = 1'b0;
    idle_bus();
    tick();
    acc(1'b1, 4'hF, 15'h0005, 32'h0);
    tick();
    idle_bus();
    chk("scan_no_write", bus.Q, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
